// File: rtl/clk_ctc8_if.sv
// Output bundle of the modulo-8 step counter: the registered select value.
// The counter drives it through the master modport and consumers read it through the slave modport.
interface clk_ctc8_if;
    logic [2:0] count;

    modport master (output count);
    modport slave  (input  count);
endinterface

// File: rtl/clk_ctc8.sv
// Free-running modulo-(COUNT_MAX+1) 3-bit counter with an optional prescaler.
// The counter steps the LED chaser pattern or scan select, and its output is always a register.
module clk_ctc8 #(
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned COUNT_MAX = 7
) (
    input  logic        clock,
    input  logic        reset,
    clk_ctc8_if.master  cnt_if
);

    localparam int unsigned PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [2:0]  MAX_VAL = 3'(COUNT_MAX);

    logic       w_step;
    logic [2:0] r_count;

    generate
        if (PRESCALE == 1) begin : g_no_prescale
            assign w_step = 1'b1;
        end else begin : g_prescale
            localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
            logic [PS_W-1:0] r_pre;

            // The step enable is decoded from the prescaler register, so it is glitch-free.
            // It is high for exactly one clock out of every PRESCALE clocks.
            assign w_step = (r_pre == PS_LAST);

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_pre <= '0;
                end else if (w_step) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= 3'd0;
        end else if (w_step) begin
            if (r_count == MAX_VAL) begin
                r_count <= 3'd0;
            end else begin
                r_count <= r_count + 3'd1;
            end
        end
    end

    assign cnt_if.count = r_count;

endmodule

// File: tb/tb_clk_ctc8.sv
// Directed bench for clk_ctc8 with three instances: the default build, PRESCALE=4, and COUNT_MAX=4.
// All three share one clock and one reset.
module tb_clk_ctc8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    clk_ctc8_if if_def ();
    clk_ctc8_if if_ps ();
    clk_ctc8_if if_cm ();

    clk_ctc8 #(.PRESCALE(1), .COUNT_MAX(7)) u_def (.clock(clock), .reset(reset), .cnt_if(if_def));
    clk_ctc8 #(.PRESCALE(4), .COUNT_MAX(7)) u_ps  (.clock(clock), .reset(reset), .cnt_if(if_ps));
    clk_ctc8 #(.PRESCALE(1), .COUNT_MAX(4)) u_cm  (.clock(clock), .reset(reset), .cnt_if(if_cm));

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [2:0] free_tab [10];
        logic [2:0] cm_tab   [6];
        int         hist     [8];
        int         wraps;
        logic [2:0] prev;

        free_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        cm_tab   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        for (int i = 0; i < 8; i++) hist[i] = 0;
        wraps = 0;
        prev  = 3'd0;

        // Reset is held for three edges, and every instance must read 0 after each of them.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_edge();
            chk("reset_hold_def", int'(if_def.count), 0);
            chk("reset_hold_ps",  int'(if_ps.count),  0);
            chk("reset_hold_cm",  int'(if_cm.count),  0);
        end

        // Release reset and run 32 edges. Edge k is the k-th edge after the release.
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step_edge();
            if (k <= 10) chk("free_run_tab", int'(if_def.count), int'(free_tab[k-1]));
            else         chk("free_run_def", int'(if_def.count), k % 8);
            if (k <= 6)  chk("cm4_tab", int'(if_cm.count), int'(cm_tab[k-1]));
            else         chk("cm4_seq", int'(if_cm.count), k % 5);
            chk("ps4_seq", int'(if_ps.count), (k / 4) % 8);
            if (k <= 24) begin
                hist[if_def.count] = hist[if_def.count] + 1;
                if (prev == 3'd7 && if_def.count == 3'd0) wraps++;
                prev = if_def.count;
            end
        end

        chk("wrap_count_24", wraps, 3);
        for (int v = 0; v < 8; v++) chk("value_hist_24", hist[v], 3);

        // The default instance reaches 5 on edge 37. Reset is then asserted for one edge.
        for (int k = 33; k <= 37; k++) step_edge();
        chk("pre_mid_reset_def", int'(if_def.count), 5);
        reset = 1'b1;
        step_edge();
        chk("mid_reset_def", int'(if_def.count), 0);
        chk("mid_reset_ps",  int'(if_ps.count),  0);
        chk("mid_reset_cm",  int'(if_cm.count),  0);

        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step_edge();
            chk("post_reset_def", int'(if_def.count), k);
            chk("post_reset_ps",  int'(if_ps.count),  (k == 4) ? 1 : 0);
            chk("post_reset_cm",  int'(if_cm.count),  k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_ctc8.md
Name: clk_ctc8

Overview:
- Free-running 3-bit modulo-8 up-counter clocked by the system clock.
- Used in the LED-light design to step an 8-position pattern or select index (LED chaser / scan select).
- Optional prescaler slows the step rate; the default advances one step per clock.
- Output is registered and glitch-free for direct use as a select bus.

Parameters:
- PRESCALE, 1: clocks per count step; legal range 1..2^16.
  - 1 = step every rising edge.
  - N = step once every N rising edges.
- COUNT_MAX, 7: terminal count before wrap to 0; legal range 1..7; default gives full modulo-8.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
- count  output 3  current counter value; registered output.

Behaviour:
- Single clock domain.
- Interface:
  - One clock, `clock`.
  - Reset `reset` is synchronous and active-high.
  - No asynchronous reset path.
- Reset:
  - On any rising edge with reset=1: count <= 0 and the internal prescaler <= 0.
  - Reset has priority over counting.
  - Asserting reset mid-count forces 0 on the next edge, regardless of the current value or prescaler phase.
  - Holding reset keeps count at 0.
- Prescaler, internal, width ceil(log2(PRESCALE)), minimum 1 bit:
  - Increments each non-reset edge.
  - On reaching PRESCALE-1 it wraps to 0 and issues a one-cycle internal step enable.
  - When PRESCALE=1 the step enable is constantly 1 and the prescaler is unused.
- Counting, on an edge with reset=0 and step enable=1:
  - If count == COUNT_MAX: count <= 0 (wrap).
  - Otherwise: count <= count + 1, computed in 3 bits.
  - Without step enable, count holds.
- Latency:
  - First step occurs PRESCALE edges after the first edge sampling reset=0.
  - With defaults, count=1 after the first non-reset edge.
- Sequence with defaults: 0,1,2,3,4,5,6,7,0,1,... with period 8 clocks; no skipped or repeated values.
- COUNT_MAX < 7: values above COUNT_MAX are never produced after reset.
- Before the first reset, count is undefined (X in simulation). A reset is required before use.
- No combinational path from any input to count.

Test Plan:
- Reset hold:
  - Stimulus: reset=1 for 3 rising edges.
  - Response: count=0 on each edge.
- Free-run, defaults:
  - Stimulus: release reset; observe 10 edges.
  - Response: count = 1,2,3,4,5,6,7,0,1,2.
- Wrap continuity, defaults:
  - Stimulus: run 24 edges after release.
  - Response: exactly 3 transitions 7->0; each value 0..7 appears 3 times.
- Reset mid-run:
  - Stimulus: assert reset for 1 edge when count=5.
  - Response: count=0 on that edge; after release, count = 1,2,...
- Prescale:
  - Stimulus: PRESCALE=4, release reset.
  - Response: count stays 0 for 3 edges, becomes 1 on edge 4, then 2 on edge 8; 7->0 occurs on edge 32.
- Reduced modulus:
  - Stimulus: COUNT_MAX=4, PRESCALE=1, release reset.
  - Response: count = 1,2,3,4,0,1; never reaches 5, 6 or 7.
